vdp_super_vram_arbiter: RTL and testbench
=========================================

Name: vdp_super_vram_arbiter

Overview:
Time-slot arbiter for the shared 32-bit VRAM port in super-res/super-mid modes. It divides each line into 4-clock slots aligned to cx[1:0]. Each slot goes to exactly one owner: display fetch, refresh, CPU port or command-engine port. The display fetch is hard real-time and always wins inside the super_res_drawing window; the other requesters get the remaining slots.

Parameters:
ADDR_W, 17, VRAM dword address width.
REFRESH_X, 723, cx value at which one refresh request is queued per line.
REFRESH_MAX, 3, saturation limit of the pending-refresh counter.

Ports:
reset  in  1  reset, asynchronous, active-high.
clk  in  1  clock clk.
vdp_super  in  1  super modes enabled; 0 = display never granted.
cx  in  10  horizontal pixel counter.
super_res_drawing  in  1  display-fetch window from the super-res block.
disp_addr  in  ADDR_W  display fetch dword address.
cpu_req  in  1  CPU request level.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W+2  CPU byte address.
cpu_wdata  in  8  CPU write byte.
cpu_ack  out  1  one-cycle completion pulse.
cpu_rdata  out  8  CPU read byte, valid with cpu_ack.
cmd_req, cmd_we, cmd_addr, cmd_wdata, cmd_ack, cmd_rdata: command-engine port, same widths and semantics as the CPU port.
mem_addr  out  ADDR_W  VRAM dword address.
mem_wdata  out  32  write data; byte replicated to all 4 lanes.
mem_be  out  4  byte enables.
mem_rd  out  1  read strobe.
mem_wr  out  1  write strobe.
mem_refresh  out  1  refresh strobe.
mem_rdata  in  32  VRAM read data.
disp_grant  out  1  current slot is owned by display fetch.

Behaviour:
- Slot phases are cx[1:0]: 0 = arbitrate, 1 = command, 2 = wait, 3 = data.
- Owner state (IDLE, DISP, REFRESH, CPU, CMD) is registered at the end of phase 0 and held through phase 3.
- Priority at phase 0:
  - DISP if vdp_super && super_res_drawing.
  - Else REFRESH if the pending counter is nonzero.
  - Else CPU/CMD by round-robin.
  - Else IDLE.
- Round-robin pointer:
  - Reset value selects CPU first.
  - After any CPU or CMD grant, the pointer points at the other port.
  - If only one port requests, that port wins regardless of the pointer.
- Requests raised during phases 1-3 wait for the next phase 0. No mid-slot preemption, even if super_res_drawing rises mid-slot.
- Phase 1 (one cycle only), per owner:
  - DISP: mem_addr = disp_addr, mem_rd = 1.
  - CPU/CMD: mem_addr = addr[ADDR_W+1:2].
    - Write: mem_wr = 1, mem_be = 1 << addr[1:0], mem_wdata = {4{wdata}}.
    - Read: mem_rd = 1, mem_be = 4'hF.
  - REFRESH: mem_refresh = 1.
  - IDLE: no strobe.
- Outside phase 1, all strobes are 0. mem_addr, mem_wdata and mem_be hold their last value.
- Phase 3 for a CPU/CMD owner: the selected byte of mem_rdata (by addr[1:0], latched at phase 0) is registered into the port's rdata. The port's ack pulses high during the following phase 0. Writes ack at the same time; rdata is unchanged on writes.
- Handshake:
  - The requester holds req, we, addr and wdata stable until ack.
  - req still high in the cycle after ack counts as a new request.
  - Ack latency is 4-7 clocks when uncontended.
- Refresh counter:
  - Increments at cx == REFRESH_X and saturates at REFRESH_MAX.
  - Decrements when a REFRESH slot is granted.
  - Simultaneous increment and decrement leaves it unchanged.
- disp_grant is high for the 4 cycles of a DISP slot.
- vdp_super = 0: the DISP owner is never chosen; CPU, CMD and refresh continue normally.
- cx wrap (last pixel back to 0) is handled by cx[1:0] alone; no special case.
- Reset values:
  - All outputs 0; owner IDLE; counter 0; pointer at CPU; latched addr[1:0] 0.
- Reset mid-slot aborts the slot with no ack. A requester still holding req is re-arbitrated after reset release.

Test Plan:
- Reset during a CPU read at phase 2 -> all outputs 0 immediately; no cpu_ack; after release with cpu_req still high, the grant comes at the next phase 0 and cpu_ack follows at the next phase 0 after that.
- CPU write, cpu_addr = 0x00006, wdata = 0xA5, issued at phase 0 with no contention -> phase 1: mem_addr = 1, mem_be = 4'b0100, mem_wdata = 0xA5A5A5A5, mem_wr = 1; cpu_ack at the next phase 0.
- CPU read, cpu_addr = 0x00003, mem_rdata = 0x11223344 at phase 3 -> cpu_rdata = 0x11, cpu_ack a single-cycle pulse.
- super_res_drawing = 1 with cpu_req and cmd_req both high -> every slot is DISP with mem_rd at phase 1 and mem_addr = disp_addr; no acks until the window drops; then CPU is granted, then CMD in the next slot.
- CPU and CMD both requesting continuously, no drawing and no refresh -> grants alternate CPU, CMD, CPU…; each ack exactly once per 8 clocks.
- Five lines with drawing held high across cx = 723 -> counter saturates at 3; after drawing drops, three consecutive REFRESH slots occur before any CPU/CMD grant.

Source files
------------

// File: rtl/vdp_super_vram_arbiter.sv
// Slot arbiter for the shared 32-bit VRAM port in super-res modes: each 4-clock slot
// (aligned to cx[1:0]) is owned by display fetch, refresh, the CPU or the command engine.
module vdp_super_vram_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int REFRESH_X   = 723,
  parameter int REFRESH_MAX = 3
) (
  input  logic                reset,
  input  logic                clk,
  input  logic                vdp_super,
  input  logic [9:0]          cx,
  input  logic                super_res_drawing,
  input  logic [ADDR_W-1:0]   disp_addr,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W+1:0]   cpu_addr,
  input  logic [7:0]          cpu_wdata,
  output logic                cpu_ack,
  output logic [7:0]          cpu_rdata,
  input  logic                cmd_req,
  input  logic                cmd_we,
  input  logic [ADDR_W+1:0]   cmd_addr,
  input  logic [7:0]          cmd_wdata,
  output logic                cmd_ack,
  output logic [7:0]          cmd_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_be,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_refresh,
  input  logic [31:0]         mem_rdata,
  output logic                disp_grant
);

  localparam int CNT_W = (REFRESH_MAX < 2) ? 1 : $clog2(REFRESH_MAX + 1);

  typedef enum logic [2:0] {
    OWN_IDLE,
    OWN_DISP,
    OWN_REFRESH,
    OWN_CPU,
    OWN_CMD
  } owner_t;

  owner_t              owner_reg;
  owner_t              winner;
  logic                rr_cmd_reg;
  logic [1:0]          sel_reg;
  logic                we_reg;
  logic [CNT_W-1:0]    refresh_cnt_reg;

  logic [1:0]          phase;
  logic                cpu_elig;
  logic                cmd_elig;
  logic                refresh_inc;
  logic                refresh_dec;
  logic [ADDR_W+1:0]   win_addr;
  logic                win_we;
  logic [7:0]          win_wdata;

  assign phase = cx[1:0];

  // A port being acked this cycle has not yet had a chance to drop req.
  assign cpu_elig = cpu_req && !cpu_ack;
  assign cmd_elig = cmd_req && !cmd_ack;

  always_comb begin
    winner = OWN_IDLE;
    if (vdp_super && super_res_drawing)
      winner = OWN_DISP;
    else if (refresh_cnt_reg != '0)
      winner = OWN_REFRESH;
    else if (cpu_elig && (!cmd_elig || !rr_cmd_reg))
      winner = OWN_CPU;
    else if (cmd_elig)
      winner = OWN_CMD;
  end

  always_comb begin
    win_addr  = cpu_addr;
    win_we    = cpu_we;
    win_wdata = cpu_wdata;
    if (winner == OWN_CMD) begin
      win_addr  = cmd_addr;
      win_we    = cmd_we;
      win_wdata = cmd_wdata;
    end
  end

  assign refresh_inc = (cx == 10'(REFRESH_X));
  assign refresh_dec = (phase == 2'd0) && (winner == OWN_REFRESH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_reg       <= OWN_IDLE;
      rr_cmd_reg      <= 1'b0;
      sel_reg         <= 2'd0;
      we_reg          <= 1'b0;
      refresh_cnt_reg <= '0;
      cpu_ack         <= 1'b0;
      cpu_rdata       <= 8'd0;
      cmd_ack         <= 1'b0;
      cmd_rdata       <= 8'd0;
      mem_addr        <= '0;
      mem_wdata       <= 32'd0;
      mem_be          <= 4'd0;
      mem_rd          <= 1'b0;
      mem_wr          <= 1'b0;
      mem_refresh     <= 1'b0;
      disp_grant      <= 1'b0;
    end else begin
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_refresh <= 1'b0;
      cpu_ack     <= 1'b0;
      cmd_ack     <= 1'b0;

      if (refresh_inc && !refresh_dec && (refresh_cnt_reg != CNT_W'(REFRESH_MAX)))
        refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
      else if (refresh_dec && !refresh_inc)
        refresh_cnt_reg <= refresh_cnt_reg - 1'b1;

      case (phase)
        2'd0: begin
          // Decision taken here drives the phase-1 command strobes directly.
          owner_reg  <= winner;
          disp_grant <= (winner == OWN_DISP);
          case (winner)
            OWN_DISP: begin
              mem_addr <= disp_addr;
              mem_rd   <= 1'b1;
            end
            OWN_REFRESH: mem_refresh <= 1'b1;
            OWN_CPU, OWN_CMD: begin
              mem_addr   <= win_addr[ADDR_W+1:2];
              sel_reg    <= win_addr[1:0];
              we_reg     <= win_we;
              rr_cmd_reg <= (winner == OWN_CPU);
              if (win_we) begin
                mem_wr    <= 1'b1;
                mem_be    <= 4'b0001 << win_addr[1:0];
                mem_wdata <= {4{win_wdata}};
              end else begin
                mem_rd <= 1'b1;
                mem_be <= 4'hF;
              end
            end
            default: ;
          endcase
        end
        2'd3: begin
          if (owner_reg == OWN_CPU) begin
            cpu_ack <= 1'b1;
            if (!we_reg)
              cpu_rdata <= mem_rdata[{sel_reg, 3'b000} +: 8];
          end
          if (owner_reg == OWN_CMD) begin
            cmd_ack <= 1'b1;
            if (!we_reg)
              cmd_rdata <= mem_rdata[{sel_reg, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Directed bench for vdp_super_vram_arbiter: slot timing, port data paths, round-robin,
// display priority, refresh saturation and mid-slot reset.
module tb_vdp_super_vram_arbiter;

  localparam int ADDR_W = 17;
  localparam int LINE   = 800;

  logic                reset;
  logic                clk;
  logic                vdp_super;
  logic [9:0]          cx;
  logic                super_res_drawing;
  logic [ADDR_W-1:0]   disp_addr;
  logic                cpu_req;
  logic                cpu_we;
  logic [ADDR_W+1:0]   cpu_addr;
  logic [7:0]          cpu_wdata;
  logic                cpu_ack;
  logic [7:0]          cpu_rdata;
  logic                cmd_req;
  logic                cmd_we;
  logic [ADDR_W+1:0]   cmd_addr;
  logic [7:0]          cmd_wdata;
  logic                cmd_ack;
  logic [7:0]          cmd_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_be;
  logic                mem_rd;
  logic                mem_wr;
  logic                mem_refresh;
  logic [31:0]         mem_rdata;
  logic                disp_grant;

  int checks = 0;
  int errors = 0;

  vdp_super_vram_arbiter #(
    .ADDR_W(ADDR_W),
    .REFRESH_X(723),
    .REFRESH_MAX(3)
  ) dut (
    .reset(reset),
    .clk(clk),
    .vdp_super(vdp_super),
    .cx(cx),
    .super_res_drawing(super_res_drawing),
    .disp_addr(disp_addr),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cmd_req(cmd_req),
    .cmd_we(cmd_we),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack),
    .cmd_rdata(cmd_rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_refresh(mem_refresh),
    .mem_rdata(mem_rdata),
    .disp_grant(disp_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, so every sample below is away from it.
  task automatic tick();
    @(posedge clk);
    #1;
    cx = (cx == 10'(LINE - 1)) ? 10'd0 : cx + 10'd1;
  endtask

  task automatic run_to_phase(input logic [1:0] p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (cx[1:0] != p && n < 8);
    if (cx[1:0] != p) begin
      errors++;
      $error("FAIL phase_wait: observed %0d expected %0d", cx[1:0], p);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int seen;
    int cyc;
    int refresh_n;
    int ack_n;

    reset = 1'b1;
    cx = 10'd0;
    vdp_super = 1'b0;
    super_res_drawing = 1'b0;
    disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'd0;
    cmd_req = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = 8'd0;
    mem_rdata = 32'd0;

    // Reset state
    tick();
    tick();
    check("rst_strobes", 32'({mem_rd, mem_wr, mem_refresh, disp_grant}), 32'd0);
    check("rst_acks", 32'({cpu_ack, cmd_ack}), 32'd0);
    check("rst_mem", 32'(mem_addr) | mem_wdata | 32'(mem_be), 32'd0);
    reset = 1'b0;

    // CPU write, byte 2 of dword 1
    run_to_phase(2'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00006; cpu_wdata = 8'hA5;
    tick();
    check("wr_addr", 32'(mem_addr), 32'd1);
    check("wr_be", 32'(mem_be), 32'h4);
    check("wr_wdata", mem_wdata, 32'hA5A5A5A5);
    check("wr_strobes", 32'({mem_wr, mem_rd}), 32'b10);
    run_to_phase(2'd0);
    check("wr_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick();
    check("wr_ack_drop", 32'({cpu_ack, mem_wr}), 32'd0);

    // CPU read, byte 3 of dword 0
    run_to_phase(2'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00003;
    mem_rdata = 32'h11223344;
    tick();
    check("rd_strobe", 32'({mem_rd, mem_wr, mem_be}), 32'b10_1111);
    check("rd_addr", 32'(mem_addr), 32'd0);
    run_to_phase(2'd0);
    check("rd_ack", 32'(cpu_ack), 32'd1);
    check("rd_data", 32'(cpu_rdata), 32'h11);
    cpu_req = 1'b0;
    tick();
    check("rd_ack_pulse", 32'(cpu_ack), 32'd0);
    check("rd_data_hold", 32'(cpu_rdata), 32'h11);

    // Reset during a CPU read at phase 2
    run_to_phase(2'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00001;
    mem_rdata = 32'hDEADBEEF;
    run_to_phase(2'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_out", 32'({cpu_rdata, mem_be, mem_rd, cpu_ack}), 32'd0);
    run_to_phase(2'd0);
    check("mid_rst_noack", 32'(cpu_ack), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_grant", 32'({mem_rd, cpu_ack}), 32'b10);
    run_to_phase(2'd0);
    check("post_rst_ack", 32'(cpu_ack), 32'd1);
    check("post_rst_data", 32'(cpu_rdata), 32'hBE);
    cpu_req = 1'b0;

    // Round-robin with both ports requesting continuously
    do_reset();
    mem_rdata = 32'h44332211;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00004;
    cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 19'h00008;
    run_to_phase(2'd0);
    for (int s = 0; s < 4; s++) begin
      run_to_phase(2'd1);
      check($sformatf("rr_addr%0d", s), 32'(mem_addr), (s % 2 == 0) ? 32'd1 : 32'd2);
      run_to_phase(2'd0);
      check($sformatf("rr_ack%0d", s), 32'({cpu_ack, cmd_ack}), (s % 2 == 0) ? 32'b10 : 32'b01);
    end
    cpu_req = 1'b0; cmd_req = 1'b0;
    run_to_phase(2'd0);
    run_to_phase(2'd0);

    // Display window owns every slot; CPU then CMD once it drops
    do_reset();
    vdp_super = 1'b1; super_res_drawing = 1'b1; disp_addr = 17'h1ABCD;
    cpu_req = 1'b1; cpu_addr = 19'h00004;
    cmd_req = 1'b1; cmd_addr = 19'h00008;
    run_to_phase(2'd0);
    for (int s = 0; s < 3; s++) begin
      run_to_phase(2'd1);
      check($sformatf("disp_fetch%0d", s), 32'({mem_rd, disp_grant, mem_addr}), {13'd0, 2'b11, 17'h1ABCD});
      run_to_phase(2'd0);
      check($sformatf("disp_noack%0d", s), 32'({disp_grant, cpu_ack, cmd_ack}), 32'b100);
    end
    super_res_drawing = 1'b0;
    run_to_phase(2'd1);
    check("after_disp_cpu", 32'({disp_grant, mem_rd, mem_addr}), {13'd0, 2'b01, 17'd1});
    run_to_phase(2'd0);
    check("after_disp_cpu_ack", 32'({cpu_ack, cmd_ack}), 32'b10);
    run_to_phase(2'd1);
    check("after_disp_cmd", 32'(mem_addr), 32'd2);
    run_to_phase(2'd0);
    check("after_disp_cmd_ack", 32'({cpu_ack, cmd_ack}), 32'b01);
    cmd_req = 1'b0;

    // vdp_super low: drawing window is ignored
    vdp_super = 1'b0; super_res_drawing = 1'b1;
    cpu_req = 1'b1; cpu_addr = 19'h0000C;
    run_to_phase(2'd1);
    check("nosuper_grant", 32'({disp_grant, mem_rd, mem_addr}), {13'd0, 2'b01, 17'd3});
    run_to_phase(2'd0);
    check("nosuper_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    super_res_drawing = 1'b0;

    // Five refresh points inside the display window, then saturated catch-up
    do_reset();
    vdp_super = 1'b1; super_res_drawing = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
    seen = 0; cyc = 0; refresh_n = 0; ack_n = 0;
    while (!(seen == 5 && cx == 10'd730) && cyc < 6000) begin
      tick();
      cyc++;
      if (cx == 10'd723) seen++;
      if (mem_refresh) refresh_n++;
      if (cpu_ack) ack_n++;
    end
    check("refresh_window_reached", 32'(seen), 32'd5);
    check("refresh_held_off", 32'(refresh_n), 32'd0);
    check("cpu_held_off", 32'(ack_n), 32'd0);
    super_res_drawing = 1'b0;
    for (int s = 0; s < 3; s++) begin
      run_to_phase(2'd1);
      check($sformatf("refresh_slot%0d", s), 32'({mem_refresh, mem_rd}), 32'b10);
    end
    run_to_phase(2'd1);
    check("refresh_then_cpu", 32'({mem_refresh, mem_rd, mem_addr}), {13'd0, 2'b01, 17'd4});
    run_to_phase(2'd0);
    check("refresh_then_cpu_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
